voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Bus-master controller that turns a stream of note-on/note-off requests into register writes on the synth's byte-wide voice bus (BusAddress/BusData/BusReadWrite/BusClock).
- Tracks which voices are gated, assigns free voices and steals round-robin when all are busy.
- Sits between the note source (MIDI decoder/sequencer) and TopLevel; it is the only bus master while enabled.

Parameters:
- NUM_VOICES, 4, number of voice slots managed (1..8).
- VOICE_BASE, 16'h0010, bus address of voice 0 Gate register.
- VOICE_STRIDE, 16'h0020, address distance between consecutive voices.

Ports:
- Clock  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- NoteValid  input  1  request present.
- NoteReady  output  1  controller can accept a request.
- NoteOn  input  1  1 = note-on, 0 = note-off.
- NoteKey  input  7  key number identifying the note.
- NoteIncr  input  24  phase increment for note-on (ignored on note-off).
- BusAddress  output  16  write address.
- BusData  output  8  write data.
- BusReadWrite  output  1  1 = write cycle in progress; 0 = idle.
- BusClock  output  1  write strobe; slave latches on rising edge.
- VoiceActive  output  NUM_VOICES  per-voice gated flag.
- Busy  output  1  high whenever FSM not in IDLE.

Behaviour:
- One clock, Clock. Reset is synchronous, active-high.
- Reset values: NoteReady=0 during reset, 1 the cycle after reset deasserts. BusAddress=0, BusData=0, BusReadWrite=0, BusClock=0, VoiceActive=0, Busy=0. Steal pointer=0. Key table cleared.
- Handshake: NoteReady=1 only in IDLE. A transfer occurs on a rising Clock with NoteValid&NoteReady; NoteOn/NoteKey/NoteIncr are captured then. NoteReady drops the following cycle.
- Voice register map (addr = VOICE_BASE + v*VOICE_STRIDE + off):
  - Gate at +0 (8'h01 open, 8'h00 closed).
  - Incr bytes at +1/+2/+3, little-endian: bits[7:0], [15:8], [23:16].
- Byte write = 3 cycles:
  - SETUP: address/data driven, BusReadWrite=1, BusClock=0.
  - STROBE: BusClock=1.
  - HOLD: BusClock=0, address/data unchanged.
  - BusReadWrite stays 1 across back-to-back bytes of one request and returns to 0 in IDLE.
- Note-on voice selection, first match wins:
  - (a) An active voice holding the same key: retrigger.
  - (b) The lowest-index inactive voice: fresh.
  - (c) Otherwise the voice at the steal pointer: steal. The pointer then increments modulo NUM_VOICES.
- Note-on write sequences:
  - Fresh: Incr0, Incr1, Incr2, Gate=01 (4 bytes, 12 cycles).
  - Retrigger/steal: Gate=00, Incr0, Incr1, Incr2, Gate=01 (5 bytes, 15 cycles).
  - On completion of the final HOLD: VoiceActive[v]=1 and table key=NoteKey. The FSM is back in IDLE (NoteReady=1) on the next cycle.
- Note-off:
  - If an active voice holds NoteKey: write Gate=00 (3 cycles), then VoiceActive[v]=0.
  - If no match: request consumed, no bus activity, IDLE next cycle.
- FSM states: IDLE -> LOOKUP (1 cycle, selection computed from table) -> SETUP -> STROBE -> HOLD -> (next byte ? SETUP : IDLE).
  - Accept-to-first-SETUP latency is 2 cycles.
- Table updates happen only at sequence end, so VoiceActive never reflects a half-written voice.
- Address arithmetic is 16-bit, wrapping modulo 2^16.
- Reset mid-sequence: bus outputs go to idle values the next cycle and the table clears. No closing writes are issued; TopLevel shares Reset.
- NUM_VOICES=1: steal always selects voice 0.

Test Plan:
- Reset, then note-on key 60, Incr 24'h0FFFFF → writes 0011=FF, 0012=FF, 0013=0F, 0010=01. Each byte is 3 cycles with BusClock high only in the middle. VoiceActive=0001. NoteReady high 14 cycles after accept.
- Note-ons keys 60,62,64,65 → voices 0..3 at gate addresses 0010/0030/0050/0070. VoiceActive=1111.
- 5th note-on, key 67, Incr 24'h000500 → steal voice 0: writes 0010=00, 0011=00, 0012=05, 0013=00, 0010=01. Steal pointer becomes 1. The next steal targets 0030.
- Note-off key 62 → single write 0030=00; VoiceActive bit1 clears. Note-off key 99 (absent) → no BusReadWrite pulse, NoteReady back in 2 cycles.
- Note-on key 64 while already active on voice 2 → retrigger voice 2 (5 writes at 0050..0053), no other voice changes.
- Assert Reset during the STROBE of a note-on → next cycle BusClock=0, BusReadWrite=0, VoiceActive=0. A fresh note-on afterwards uses voice 0.

Source files
------------

// File: rtl/voice_allocator.sv
// Voice allocator: turns note-on/note-off requests into byte-wide voice
// register writes, tracking gated voices and stealing round-robin.
module voice_allocator #(
  parameter int          NUM_VOICES   = 4,
  parameter logic [15:0] VOICE_BASE   = 16'h0010,
  parameter logic [15:0] VOICE_STRIDE = 16'h0020
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  NoteValid,
  output logic                  NoteReady,
  input  logic                  NoteOn,
  input  logic [6:0]            NoteKey,
  input  logic [23:0]           NoteIncr,
  output logic [15:0]           BusAddress,
  output logic [7:0]            BusData,
  output logic                  BusReadWrite,
  output logic                  BusClock,
  output logic [NUM_VOICES-1:0] VoiceActive,
  output logic                  Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  state_t state_q, state_d;

  logic        on_q;
  logic [6:0]  key_q;
  logic [23:0] incr_q;
  logic [2:0]  voice_q, voice_d;
  logic [2:0]  step_q, step_d;
  logic [2:0]  last_q, last_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] off_d;

  logic [NUM_VOICES-1:0] active_q;
  logic [6:0]            key_tab [NUM_VOICES];

  logic       hit, free;
  logic [2:0] hit_v, free_v;

  // Descending scan so the lowest index wins.
  always_comb begin
    hit    = 1'b0;
    hit_v  = 3'd0;
    free   = 1'b0;
    free_v = 3'd0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active_q[i] && key_tab[i] == key_q) begin
        hit   = 1'b1;
        hit_v = 3'(i);
      end
      if (!active_q[i]) begin
        free   = 1'b1;
        free_v = 3'(i);
      end
    end
  end

  // Steps: 0 gate off, 1..3 incr bytes, 4 gate on.
  // Fresh voices start at step 1; note-off runs step 0 only.
  always_comb begin
    state_d = state_q;
    voice_d = voice_q;
    step_d  = step_q;
    last_d  = last_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (NoteValid)
          state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        state_d = S_SETUP;
        step_d  = 3'd0;
        last_d  = on_q ? 3'd4 : 3'd0;
        if (!on_q) begin
          if (hit)
            voice_d = hit_v;
          else
            state_d = S_IDLE;
        end else if (hit) begin
          voice_d = hit_v;
        end else if (free) begin
          voice_d = free_v;
          step_d  = 3'd1;
        end else begin
          voice_d = ptr_q;
          ptr_d   = (ptr_q == 3'(NUM_VOICES - 1))
                    ? 3'd0 : ptr_q + 3'd1;
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = S_HOLD;
      S_HOLD: begin
        if (step_q == last_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SETUP;
          step_d  = step_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    off_d  = 16'd0;
    data_d = 8'h00;
    case (step_d)
      3'd0: begin
        off_d  = 16'd0;
        data_d = 8'h00;
      end
      3'd1: begin
        off_d  = 16'd1;
        data_d = incr_q[7:0];
      end
      3'd2: begin
        off_d  = 16'd2;
        data_d = incr_q[15:8];
      end
      3'd3: begin
        off_d  = 16'd3;
        data_d = incr_q[23:16];
      end
      default: begin
        off_d  = 16'd0;
        data_d = 8'h01;
      end
    endcase
    addr_d = VOICE_BASE
           + (16'(voice_d) * VOICE_STRIDE)
           + off_d;
  end

  always_ff @(posedge Clock) begin
    if (Reset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      on_q     <= 1'b0;
      key_q    <= 7'd0;
      incr_q   <= 24'd0;
      voice_q  <= 3'd0;
      step_q   <= 3'd0;
      last_q   <= 3'd0;
      ptr_q    <= 3'd0;
      addr_q   <= 16'd0;
      data_q   <= 8'd0;
      active_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++)
        key_tab[i] <= 7'd0;
    end else begin
      if (state_q == S_IDLE && NoteValid) begin
        on_q   <= NoteOn;
        key_q  <= NoteKey;
        incr_q <= NoteIncr;
      end
      voice_q <= voice_d;
      step_q  <= step_d;
      last_q  <= last_d;
      ptr_q   <= ptr_d;
      if (state_d == S_SETUP) begin
        addr_q <= addr_d;
        data_q <= data_d;
      end
      // Table commits only after the final byte's hold.
      if (state_q == S_HOLD && step_q == last_q) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (3'(i) == voice_q) begin
            active_q[i] <= on_q;
            if (on_q)
              key_tab[i] <= key_q;
          end
        end
      end
    end
  end

  assign NoteReady    = (state_q == S_IDLE) && !Reset;
  assign Busy         = (state_q != S_IDLE);
  assign BusReadWrite = (state_q == S_SETUP)
                     || (state_q == S_STROBE)
                     || (state_q == S_HOLD);
  assign BusClock     = (state_q == S_STROBE);
  assign BusAddress   = addr_q;
  assign BusData      = data_q;
  assign VoiceActive  = active_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed vector table, reset corner case,
// and random note traffic against a behavioural voice model.
module tb_voice_allocator;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        NoteValid;
  logic        NoteReady;
  logic        NoteOn;
  logic [6:0]  NoteKey;
  logic [23:0] NoteIncr;
  logic [15:0] BusAddress;
  logic [7:0]  BusData;
  logic        BusReadWrite;
  logic        BusClock;
  logic [3:0]  VoiceActive;
  logic        Busy;

  voice_allocator #(
    .NUM_VOICES(4),
    .VOICE_BASE(16'h0010),
    .VOICE_STRIDE(16'h0020)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .NoteValid(NoteValid),
    .NoteReady(NoteReady),
    .NoteOn(NoteOn),
    .NoteKey(NoteKey),
    .NoteIncr(NoteIncr),
    .BusAddress(BusAddress),
    .BusData(BusData),
    .BusReadWrite(BusReadWrite),
    .BusClock(BusClock),
    .VoiceActive(VoiceActive),
    .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  logic [23:0] wq[$];
  logic [23:0] eq[$];
  logic        tr_rw[$];
  logic        tr_clk[$];
  logic        tr_busy[$];
  logic [15:0] tr_a[$];
  logic [7:0]  tr_d[$];

  bit m_act[4];
  int m_key[4];
  int m_ptr;

  typedef struct {
    bit          on;
    logic [6:0]  key;
    logic [23:0] incr;
    int          lat;
    int          nb;
    logic [23:0] first;
    logic [23:0] last;
    logic [3:0]  act;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 0;
      m_key[i] = 0;
    end
    m_ptr = 0;
  endtask

  task automatic put(input int v, input int off, input int d);
    int a;
    a = 'h10 + v * 'h20 + off;
    eq.push_back({a[15:0], d[7:0]});
  endtask

  task automatic model_note(input bit on, input int key,
                            input int incr, output int lat);
    int v;
    bit kill;
    eq.delete();
    v = -1;
    for (int i = 0; i < 4; i++)
      if (v < 0 && m_act[i] && m_key[i] == key) v = i;
    if (!on) begin
      if (v >= 0) begin
        put(v, 0, 0);
        m_act[v] = 0;
      end
    end else begin
      kill = (v >= 0);
      for (int i = 0; i < 4; i++)
        if (v < 0 && !m_act[i]) v = i;
      if (v < 0) begin
        v = m_ptr;
        m_ptr = (m_ptr + 1) % 4;
        kill = 1;
      end
      if (kill) put(v, 0, 0);
      put(v, 1, incr & 255);
      put(v, 2, (incr >> 8) & 255);
      put(v, 3, (incr >> 16) & 255);
      put(v, 0, 1);
      m_act[v] = 1;
      m_key[v] = key;
    end
    lat = 2 + 3 * eq.size();
  endtask

  function automatic logic [3:0] model_act();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_act[i];
    return r;
  endfunction

  task automatic send_note(input bit on, input logic [6:0] key,
                           input logic [23:0] incr, output int lat);
    int guard;
    wq.delete();
    tr_rw.delete();
    tr_clk.delete();
    tr_busy.delete();
    tr_a.delete();
    tr_d.delete();
    @(negedge Clock);
    NoteValid = 1'b1;
    NoteOn    = on;
    NoteKey   = key;
    NoteIncr  = incr;
    guard = 0;
    while (!NoteReady && guard < 50) begin
      @(negedge Clock);
      guard++;
    end
    @(posedge Clock);
    #1;
    NoteValid = 1'b0;
    lat = 0;
    do begin
      @(negedge Clock);
      lat++;
      tr_rw.push_back(BusReadWrite);
      tr_clk.push_back(BusClock);
      tr_busy.push_back(Busy);
      tr_a.push_back(BusAddress);
      tr_d.push_back(BusData);
      if (BusClock) wq.push_back({BusAddress, BusData});
    end while (!NoteReady && lat < 100);
    if (guard >= 50) lat = -1;
  endtask

  task automatic cmp_model(input string tag, input int lat,
                           input int mlat);
    int n;
    chk({tag, " latency"}, lat, mlat);
    chk({tag, " nwrites"}, wq.size(), eq.size());
    n = (wq.size() < eq.size()) ? wq.size() : eq.size();
    for (int k = 0; k < n; k++)
      chk($sformatf("%s write%0d", tag, k), wq[k], eq[k]);
    chk({tag, " active"}, VoiceActive, model_act());
  endtask

  logic [15:0] exp_a[4];
  logic [7:0]  exp_d[4];

  initial begin
    int lat, mlat, guard, c;
    bit on;
    logic [6:0] key;
    logic [23:0] incr;

    vecs[0] = '{1, 7'd60, 24'h0FFFFF, 14, 4, 24'h0011FF, 24'h001001, 4'b0001};
    vecs[1] = '{1, 7'd62, 24'h000100, 14, 4, 24'h003100, 24'h003001, 4'b0011};
    vecs[2] = '{1, 7'd64, 24'h000200, 14, 4, 24'h005100, 24'h005001, 4'b0111};
    vecs[3] = '{1, 7'd65, 24'h000300, 14, 4, 24'h007100, 24'h007001, 4'b1111};
    vecs[4] = '{1, 7'd67, 24'h000500, 17, 5, 24'h001000, 24'h001001, 4'b1111};
    vecs[5] = '{0, 7'd62, 24'h000000,  5, 1, 24'h003000, 24'h003000, 4'b1101};
    vecs[6] = '{0, 7'd99, 24'h000000,  2, 0, 24'h000000, 24'h000000, 4'b1101};
    vecs[7] = '{1, 7'd64, 24'h000700, 17, 5, 24'h005000, 24'h005001, 4'b1101};
    vecs[8] = '{1, 7'd70, 24'h000001, 14, 4, 24'h003101, 24'h003001, 4'b1111};
    vecs[9] = '{1, 7'd72, 24'h000002, 17, 5, 24'h003000, 24'h003001, 4'b1111};
    exp_a = '{16'h0011, 16'h0012, 16'h0013, 16'h0010};
    exp_d = '{8'hFF, 8'hFF, 8'h0F, 8'h01};

    NoteValid = 0;
    NoteOn    = 0;
    NoteKey   = 0;
    NoteIncr  = 0;
    Reset     = 1;
    repeat (3) @(negedge Clock);
    chk("reset ready", NoteReady, 0);
    chk("reset addr", BusAddress, 0);
    chk("reset data", BusData, 0);
    chk("reset rw", BusReadWrite, 0);
    chk("reset clk", BusClock, 0);
    chk("reset active", VoiceActive, 0);
    chk("reset busy", Busy, 0);
    Reset = 0;
    @(negedge Clock);
    chk("ready after reset", NoteReady, 1);
    model_reset();

    for (int i = 0; i < 10; i++) begin
      send_note(vecs[i].on, vecs[i].key, vecs[i].incr, lat);
      model_note(vecs[i].on, vecs[i].key, vecs[i].incr, mlat);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d nwrites", i), wq.size(), vecs[i].nb);
      chk($sformatf("vec%0d active", i), VoiceActive, vecs[i].act);
      if (vecs[i].nb > 0 && wq.size() > 0) begin
        chk($sformatf("vec%0d first", i), wq[0], vecs[i].first);
        chk($sformatf("vec%0d last", i), wq[wq.size()-1], vecs[i].last);
      end
      cmp_model($sformatf("vec%0d model", i), lat, mlat);
      if (i == 0) begin
        chk("trace len", tr_rw.size(), 14);
        for (int k = 0; k < tr_rw.size() && k < 14; k++) begin
          c = k + 1;
          chk($sformatf("cyc%0d rw", c), tr_rw[k],
              (c >= 2 && c <= 13) ? 1 : 0);
          chk($sformatf("cyc%0d clk", c), tr_clk[k],
              (c >= 2 && c <= 13 && (c - 2) % 3 == 1) ? 1 : 0);
          chk($sformatf("cyc%0d busy", c), tr_busy[k],
              (c <= 13) ? 1 : 0);
          if (c >= 2 && c <= 13) begin
            chk($sformatf("cyc%0d addr", c), tr_a[k], exp_a[(c-2)/3]);
            chk($sformatf("cyc%0d data", c), tr_d[k], exp_d[(c-2)/3]);
          end
        end
      end
    end

    // Reset landing on a strobe.
    @(negedge Clock);
    NoteValid = 1;
    NoteOn    = 1;
    NoteKey   = 7'd61;
    NoteIncr  = 24'h123456;
    @(posedge Clock);
    #1;
    NoteValid = 0;
    guard = 0;
    do begin
      @(negedge Clock);
      guard++;
    end while (!BusClock && guard < 40);
    chk("midreset strobe seen", BusClock, 1);
    Reset = 1;
    @(posedge Clock);
    #1;
    chk("midreset clk", BusClock, 0);
    chk("midreset rw", BusReadWrite, 0);
    chk("midreset active", VoiceActive, 0);
    chk("midreset ready", NoteReady, 0);
    @(negedge Clock);
    Reset = 0;
    @(posedge Clock);
    #1;
    chk("midreset ready after", NoteReady, 1);
    model_reset();
    send_note(1, 7'd80, 24'h00ABCD, lat);
    model_note(1, 80, 24'h00ABCD, mlat);
    chk("post reset first write", (wq.size() > 0) ? wq[0] : 24'hx,
        24'h0011CD);
    cmp_model("post reset", lat, mlat);

    for (int r = 0; r < 80; r++) begin
      on   = ($urandom % 3) != 0;
      key  = 7'(60 + $urandom % 8);
      incr = 24'($urandom);
      send_note(on, key, incr, lat);
      model_note(on, int'(key), int'(incr), mlat);
      cmp_model($sformatf("rand%0d", r), lat, mlat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
